exe_stage: RTL

Execute stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the ID/EXE pipeline register and upstream of the EXE/MEM register. It computes ALU, shift, move and multiply results combinationally, and runs a 32-iteration sequential divider that stalls the front of the pipeline. It forwards HI/LO from the MEM and WB stages.

---
 rtl/exe_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// MIPS32 execute stage: single-cycle ALU/shift/move/multiply plus a
// 32-iteration restoring divider that stalls the front of the pipeline.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [2:0]  exe_alutype_i,
  input  logic [7:0]  exe_aluop_i,
  input  logic [31:0] exe_src1_i,
  input  logic [31:0] exe_src2_i,
  input  logic [4:0]  exe_wa_i,
  input  logic        exe_wreg_i,
  input  logic        exe_mreg_i,
  input  logic [31:0] exe_din_i,
  input  logic        exe_whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [63:0] mem_hilo_i,
  input  logic        wb_whilo_i,
  input  logic [63:0] wb_hilo_i,
  output logic [7:0]  exe_aluop_o,
  output logic [4:0]  exe_wa_o,
  output logic        exe_mreg_o,
  output logic [31:0] exe_din_o,
  output logic        exe_wreg_o,
  output logic        exe_whilo_o,
  output logic [31:0] exe_wd_o,
  output logic [63:0] exe_hilo_o,
  output logic        stall_req
);

  localparam logic [2:0] T_ARITH = 3'd1, T_LOGIC = 3'd2, T_MOVE = 3'd3,
                         T_SHIFT = 3'd4, T_MULDIV = 3'd5;
  localparam logic [7:0] OP_ADD = 8'h18, OP_SUB = 8'h1A, OP_SLT = 8'h1B, OP_SLTU = 8'h1C,
                         OP_AND = 8'h1D, OP_OR = 8'h1E, OP_XOR = 8'h1F, OP_NOR = 8'h20,
                         OP_LUI = 8'h21, OP_SLL = 8'h22, OP_SRL = 8'h23, OP_SRA = 8'h24,
                         OP_MFHI = 8'h25, OP_MFLO = 8'h26, OP_MULT = 8'h27, OP_MULTU = 8'h28,
                         OP_DIV = 8'h29, OP_DIVU = 8'h2A, OP_MTHI = 8'h2B, OP_MTLO = 8'h2C;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvs;
  logic        neg_q, neg_r;
  logic [63:0] div_res;

  logic        is_div, div_signed;
  logic [31:0] mag1, mag2;
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] rem_nxt, quo_nxt;
  logic [63:0] hilo_fw;

  assign is_div     = (exe_alutype_i == T_MULDIV) &&
                      (exe_aluop_i == OP_DIV || exe_aluop_i == OP_DIVU);
  assign div_signed = (exe_aluop_i == OP_DIV);
  assign mag1 = (div_signed && exe_src1_i[31]) ? -exe_src1_i : exe_src1_i;
  assign mag2 = (div_signed && exe_src2_i[31]) ? -exe_src2_i : exe_src2_i;

  // Partial remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = ~diff[32];
  assign rem_nxt = fits ? diff[31:0] : shifted[31:0];
  assign quo_nxt = {quo[30:0], fits};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            if (exe_src2_i == 32'd0) begin
              div_res <= {exe_src1_i, 32'hFFFF_FFFF};
              state   <= DONE;
            end else begin
              rem   <= '0;
              quo   <= mag1;
              dvs   <= mag2;
              neg_q <= div_signed & (exe_src1_i[31] ^ exe_src2_i[31]);
              neg_r <= div_signed & exe_src1_i[31];
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            div_res <= {neg_r ? -rem_nxt : rem_nxt, neg_q ? -quo_nxt : quo_nxt};
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_req = !rst && (((state == IDLE) && is_div) || (state == BUSY));

  assign hilo_fw = mem_whilo_i ? mem_hilo_i :
                   wb_whilo_i  ? wb_hilo_i  : {hi_i, lo_i};

  always_comb begin
    exe_wd_o   = '0;
    exe_hilo_o = '0;
    case (exe_alutype_i)
      T_ARITH: case (exe_aluop_i)
        OP_ADD:  exe_wd_o = exe_src1_i + exe_src2_i;
        OP_SUB:  exe_wd_o = exe_src1_i - exe_src2_i;
        OP_SLT:  exe_wd_o = {31'd0, $signed(exe_src1_i) < $signed(exe_src2_i)};
        OP_SLTU: exe_wd_o = {31'd0, exe_src1_i < exe_src2_i};
        default: exe_wd_o = '0;
      endcase
      T_LOGIC: case (exe_aluop_i)
        OP_AND:  exe_wd_o = exe_src1_i & exe_src2_i;
        OP_OR:   exe_wd_o = exe_src1_i | exe_src2_i;
        OP_XOR:  exe_wd_o = exe_src1_i ^ exe_src2_i;
        OP_NOR:  exe_wd_o = ~(exe_src1_i | exe_src2_i);
        OP_LUI:  exe_wd_o = {exe_src2_i[15:0], 16'd0};
        default: exe_wd_o = '0;
      endcase
      T_SHIFT: case (exe_aluop_i)
        OP_SLL:  exe_wd_o = exe_src2_i << exe_src1_i[4:0];
        OP_SRL:  exe_wd_o = exe_src2_i >> exe_src1_i[4:0];
        OP_SRA:  exe_wd_o = $signed(exe_src2_i) >>> exe_src1_i[4:0];
        default: exe_wd_o = '0;
      endcase
      T_MOVE: case (exe_aluop_i)
        OP_MFHI: exe_wd_o = hilo_fw[63:32];
        OP_MFLO: exe_wd_o = hilo_fw[31:0];
        default: exe_wd_o = '0;
      endcase
      T_MULDIV: case (exe_aluop_i)
        OP_MULT:  exe_hilo_o = {{32{exe_src1_i[31]}}, exe_src1_i} *
                               {{32{exe_src2_i[31]}}, exe_src2_i};
        OP_MULTU: exe_hilo_o = {32'd0, exe_src1_i} * {32'd0, exe_src2_i};
        OP_DIV, OP_DIVU: exe_hilo_o = div_res;
        OP_MTHI:  exe_hilo_o = {exe_src1_i, hilo_fw[31:0]};
        OP_MTLO:  exe_hilo_o = {hilo_fw[63:32], exe_src1_i};
        default:  exe_hilo_o = '0;
      endcase
      default: ;
    endcase
  end

  assign exe_aluop_o = exe_aluop_i;
  assign exe_wa_o    = exe_wa_i;
  assign exe_mreg_o  = exe_mreg_i;
  assign exe_din_o   = exe_din_i;
  assign exe_wreg_o  = exe_wreg_i  && !stall_req && !rst;
  assign exe_whilo_o = exe_whilo_i && !stall_req && !rst;

endmodule
